// File: rtl/hart_sched_pkg.sv
// Shared types and sizing for the multi-hart issue scheduler.
// Lifecycle state codes and the decode that folds the unused code into IDLE live here.
package hart_sched_pkg;

    localparam int HART_NUM  = 4;
    localparam int HART_ID_W = 2;
    localparam int QUANTUM   = 4;
    localparam int QCNT_W    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    typedef logic [HART_ID_W-1:0] hart_id_t;

    typedef enum logic [1:0] {
        HART_IDLE   = 2'b00,
        HART_ACTIVE = 2'b01,
        HART_PEND   = 2'b10
    } hart_state_e;

    // The spare code 2'b11 is never written but must behave as IDLE if it appears.
    function automatic hart_state_e decodeState(input logic [1:0] raw);
        case (raw)
            2'b01:   return HART_ACTIVE;
            2'b10:   return HART_PEND;
            default: return HART_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hart_sched_if.sv
// Request/issue bundle between the hart control logic and the scheduler.
// The master side raises lifecycle requests; the slave side reports issue and status.
interface hart_sched_if;
    import hart_sched_pkg::*;

    logic                stall;
    logic                hstart;
    hart_id_t            hs_id;
    logic                hkill;
    hart_id_t            hk_id;
    logic                hpend;
    hart_id_t            hp_id;
    logic                hresume;
    hart_id_t            hr_id;
    hart_id_t            hart_id;
    logic                issue_en;
    logic                hidle;
    logic                hstart_ack;
    logic [HART_NUM-1:0] active_mask;
    logic [HART_NUM-1:0] pend_mask;

    modport master (
        output stall, hstart, hs_id, hkill, hk_id, hpend, hp_id, hresume, hr_id,
        input  hart_id, issue_en, hidle, hstart_ack, active_mask, pend_mask
    );

    modport slave (
        input  stall, hstart, hs_id, hkill, hk_id, hpend, hp_id, hresume, hr_id,
        output hart_id, issue_en, hidle, hstart_ack, active_mask, pend_mask
    );

endinterface

// File: rtl/hart_sched_rr_pick.sv
// Combinational round-robin picker: first requesting hart after the last grant,
// wrapping around and ending with the last grant itself.
module hart_sched_rr_pick
    import hart_sched_pkg::*;
(
    input  logic [HART_NUM-1:0] reqMask_i,
    input  hart_id_t            lastGrant_i,
    output hart_id_t            grant_o,
    output logic                valid_o
);

    hart_id_t idx;

    // HART_NUM is a power of two, so truncating the sum gives the modulo wrap.
    always_comb begin
        grant_o = lastGrant_i;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= HART_NUM; k++) begin
            idx = hart_id_t'(lastGrant_i + hart_id_t'(k));
            if (!valid_o && reqMask_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hart_sched.sv
// Per-cycle hart issue scheduler: tracks IDLE/ACTIVE/PEND per hart and rotates issue.
// Define HART_SCHED_QUANTUM_EN to keep each hart for QUANTUM consecutive issue slots.
module hart_sched
    import hart_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    hart_sched_if.slave bus
);

    logic [HART_NUM-1:0][1:0] state_q;
    logic [HART_NUM-1:0][1:0] state_d;
    hart_state_e              curState [HART_NUM];
    hart_state_e              nxtState [HART_NUM];
    logic [HART_NUM-1:0]      nextActive;
    logic [HART_NUM-1:0]      nextPend;
    logic [HART_NUM-1:0]      activeMask_q;
    logic [HART_NUM-1:0]      pendMask_q;
    hart_id_t                 hartId_q;
    hart_id_t                 hartId_d;
    logic                     issueEn_q;
    logic                     issueEn_d;
    logic                     hidle;
    logic                     startAck;
    hart_id_t                 pickId;
    logic                     pickValid;
`ifdef HART_SCHED_QUANTUM_EN
    logic [QCNT_W-1:0]        qCnt_q;
    logic [QCNT_W-1:0]        qCnt_d;
`endif

    always_comb begin
        for (int i = 0; i < HART_NUM; i++) begin
            curState[i] = decodeState(state_q[i]);
        end
    end

    // Starting the hart currently on hart_id is refused so a stale slot never issues it early.
    assign hidle    = (curState[bus.hs_id] == HART_IDLE);
    assign startAck = bus.hstart && hidle && (bus.hs_id != hartId_q);

    // Each request only qualifies in its source state, so only kill needs explicit priority.
    always_comb begin
        for (int i = 0; i < HART_NUM; i++) begin
            nxtState[i] = curState[i];
            if (bus.hkill && (bus.hk_id == hart_id_t'(i))) begin
                nxtState[i] = HART_IDLE;
            end else if (bus.hpend && (bus.hp_id == hart_id_t'(i)) && (curState[i] == HART_ACTIVE)) begin
                nxtState[i] = HART_PEND;
            end else if (bus.hresume && (bus.hr_id == hart_id_t'(i)) && (curState[i] == HART_PEND)) begin
                nxtState[i] = HART_ACTIVE;
            end else if (startAck && (bus.hs_id == hart_id_t'(i))) begin
                nxtState[i] = HART_ACTIVE;
            end
            state_d[i]    = nxtState[i];
            nextActive[i] = (nxtState[i] == HART_ACTIVE);
            nextPend[i]   = (nxtState[i] == HART_PEND);
        end
    end

    hart_sched_rr_pick u_pick (
        .reqMask_i   (nextActive),
        .lastGrant_i (hartId_q),
        .grant_o     (pickId),
        .valid_o     (pickValid)
    );

    // A stall freezes the slot, but a kill/pend of the frozen hart must still revoke issue.
    always_comb begin
        hartId_d  = hartId_q;
        issueEn_d = issueEn_q && nextActive[hartId_q];
`ifdef HART_SCHED_QUANTUM_EN
        qCnt_d    = qCnt_q;
        if (!bus.stall) begin
            if (issueEn_q && nextActive[hartId_q] && (qCnt_q != QCNT_W'(QUANTUM - 1))) begin
                qCnt_d    = qCnt_q + 1'b1;
                issueEn_d = 1'b1;
            end else begin
                qCnt_d    = '0;
                issueEn_d = pickValid;
                if (pickValid) begin
                    hartId_d = pickId;
                end
            end
        end
`else
        if (!bus.stall) begin
            issueEn_d = pickValid;
            if (pickValid) begin
                hartId_d = pickId;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= '0;
            state_q[0]   <= HART_ACTIVE;
            activeMask_q <= HART_NUM'(1);
            pendMask_q   <= '0;
            hartId_q     <= '0;
            issueEn_q    <= 1'b1;
`ifdef HART_SCHED_QUANTUM_EN
            qCnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            activeMask_q <= nextActive;
            pendMask_q   <= nextPend;
            hartId_q     <= hartId_d;
            issueEn_q    <= issueEn_d;
`ifdef HART_SCHED_QUANTUM_EN
            qCnt_q       <= qCnt_d;
`endif
        end
    end

    assign bus.hart_id     = hartId_q;
    assign bus.issue_en    = issueEn_q;
    assign bus.hidle       = hidle;
    assign bus.hstart_ack  = startAck;
    assign bus.active_mask = activeMask_q;
    assign bus.pend_mask   = pendMask_q;

endmodule

// File: doc/hart_sched.md
Name: hart_sched

Overview:
- Per-cycle hart issue scheduler for the FMRT Mini Core multi-hart front end.
- Keeps a lifecycle state (IDLE/ACTIVE/PEND) for every hart.
- Each unstalled cycle, picks the next ACTIVE hart in round-robin order and drives it to the IF stage as hart_id.
- Arbitrates hart start, kill, pend and resume requests, and reports the idle status that the IF stage needs before it accepts a start PC.

Parameters:
- HART_NUM, 4, number of hardware harts (power of two, 2..8).
- HART_ID_W, 2, hart id width, equal to log2(HART_NUM).
- QUANTUM, 4, consecutive issue slots per hart; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall; schedule and quantum counter hold.
- hstart  in  1  request to start the hart given by hs_id.
- hs_id  in  HART_ID_W  hart to start.
- hkill  in  1  request to return the hart given by hk_id to IDLE.
- hk_id  in  HART_ID_W  hart to kill.
- hpend  in  1  request to park the hart given by hp_id (long-latency event).
- hp_id  in  HART_ID_W  hart to pend.
- hresume  in  1  request to return the hart given by hr_id from PEND to ACTIVE.
- hr_id  in  HART_ID_W  hart to resume.
- hart_id  out  HART_ID_W  registered; hart to issue this cycle.
- issue_en  out  1  registered; hart_id is valid and ACTIVE.
- hidle  out  1  combinational; 1 when hart hs_id is IDLE.
- hstart_ack  out  1  combinational; the hstart request is accepted this cycle.
- active_mask  out  HART_NUM  registered; bit i is 1 when hart i is ACTIVE.
- pend_mask  out  HART_NUM  registered; bit i is 1 when hart i is PEND.

Behaviour:
- State encoding per hart: IDLE=2'b00, ACTIVE=2'b01, PEND=2'b10; 2'b11 is illegal and decodes as IDLE.
- Reset values:
  - hart 0 ACTIVE, all other harts IDLE.
  - hart_id=0, issue_en=1.
  - active_mask=...0001, pend_mask=0.
  - quantum counter=0.
- State transitions, applied at posedge and never gated by stall:
  - hstart: IDLE->ACTIVE, only when the target is IDLE and hs_id != hart_id. hstart_ack = hstart & hidle & (hs_id != hart_id). A start aimed at a non-IDLE hart is ignored.
  - hkill: any state -> IDLE.
  - hpend: ACTIVE->PEND; ignored in any other state.
  - hresume: PEND->ACTIVE; ignored in any other state.
  - Requests aimed at different harts in the same cycle all take effect.
  - Requests aimed at the same hart resolve by priority kill > pend > resume > start.
- Selection, only when stall=0:
  - Candidate set = harts ACTIVE in the next-state vector, i.e. including this cycle's updates.
  - next hart_id = first candidate scanning hart_id+1, hart_id+2, ... with modulo-HART_NUM wrap, ending with hart_id itself.
  - issue_en <= 1 when any candidate exists, otherwise 0 and hart_id holds.
- When stall=1: hart_id and issue_en hold. If the current hart_id is killed or pended while stalled, issue_en drops to 0 on the next edge.
- Latency: a hart started in cycle N can first appear on hart_id at edge N+1.
- Reset asserted mid-operation overrides every request in the same cycle.

Optional Feature:
- Macro: HART_SCHED_QUANTUM_EN.
- When defined:
  - A $clog2(QUANTUM)-bit counter counts the issue slots the current hart has used.
  - hart_id advances only when the counter reaches QUANTUM-1 or the current hart leaves ACTIVE.
  - The counter clears on every switch and holds while stall=1.
- When undefined: the counter is absent and hart_id rotates every unstalled cycle.

Decomposition:
- Shared package/header (hart_ctrl.h):
  - HART_NUM, HART_ID_W and the HART_ID_B bus macro.
  - State codes HART_IDLE, HART_ACTIVE, HART_PEND.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: HART_NUM-bit request mask and HART_ID_W-bit last grant.
  - Outputs: granted id and a valid bit.

Test Plan:
- Reset, 8 cycles with no requests -> hart_id=0 every cycle, issue_en=1, active_mask=4'b0001.
- hstart with hs_id=2 at cycle 1, then hs_id=3 at cycle 2 -> hart_id sequence 0,2,3,0,2,3.
- Harts 0,1,2 ACTIVE, then hpend on hp_id=1 -> hart 1 skipped with sequence 0,2,0,2; hresume on hr_id=1 -> sequence 0,1,2 returns.
- hkill on the current hart 0 while it is the only ACTIVE hart -> issue_en=0 on the next edge and hart_id holds at 0; a later hstart of hart 1 -> issue_en=1 with hart_id=1.
- hstart on hart 1 while hart 1 is ACTIVE -> hidle=0, hstart_ack=0, no state change. hstart and hkill on hart 2 in the same cycle -> hart 2 stays IDLE.
- stall held for 3 cycles with harts 0 and 1 ACTIVE -> hart_id frozen. With HART_SCHED_QUANTUM_EN and QUANTUM=4 -> sequence 0,0,0,0,1,1,1,1, and stalled cycles do not consume quantum.
